cpu_wr_qual: RTL

- Write-qualification stage in front of the dual-port CPU/MCU buffer RAM.
- Takes the asynchronous cartridge-bus CPU write strobes, synchronises and glitch-filters them into the MCU clock domain, and emits exactly one registered write pulse per CPU bus write, with captured address, data and byte enables, which the RAM write ports consume.
- Also counts writes and raises a sticky doorbell flag to the MCU when the CPU writes the mailbox word.

---
 rtl/cpu_wr_qual.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cpu_wr_qual.sv
// CPU write qualifier: synchronises and glitch-filters the cartridge-bus write strobe into clk,
// emits one registered write pulse per bus write, counts writes and raises a mailbox doorbell.
// Optional: define WR_CNT_EN to implement the wr_cnt write counter (otherwise tied to 0).
module cpu_wr_qual #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILT_CYCLES   = 2,
    parameter int ADDR_LIMIT    = 8192,
    parameter int DOORBELL_ADDR = 'h1FFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_dato,
    input  logic        cpu_ce_lo,
    input  logic        cpu_we_hi,
    input  logic        cpu_we_lo,
    input  logic        irq_clr,
    output logic        wr_stb,
    output logic [12:0] wr_addr,
    output logic [15:0] wr_dat,
    output logic [1:0]  wr_be,
    output logic [15:0] wr_cnt,
    output logic        db_irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_FIRE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam int             FW        = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [FW-1:0]  FILT_ONE  = FW'(1);
    localparam logic [23:0]    ADDR_LIM  = 24'(ADDR_LIMIT);
    localparam logic [11:0]    DB_WORD   = 12'(DOORBELL_ADDR >> 1);

    logic                   act_raw;
    logic                   act_s;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   wr_stb_q, wr_stb_d;
    logic [12:0]            wr_addr_q, wr_addr_d;
    logic [15:0]            wr_dat_q, wr_dat_d;
    logic [1:0]             wr_be_q, wr_be_d;
    logic                   db_irq_q, db_irq_d;

    // Only this one bit crosses domains; the bus is stable while the strobe is held.
    assign act_raw = cpu_ce_lo & (cpu_we_hi | cpu_we_lo) & (cpu_addr < ADDR_LIM);

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = act_raw;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign act_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        filt_cnt_d = filt_cnt_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_dat_d   = wr_dat_q;
        wr_be_d    = wr_be_q;
        case (state_q)
            ST_IDLE: begin
                if (act_s) begin
                    // The IDLE cycle that sees act_s high is the first filtered cycle.
                    if (FILT_CYCLES == 1) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d    = ST_QUAL;
                        filt_cnt_d = FILT_ONE;
                    end
                end
            end
            ST_QUAL: begin
                if (!act_s) begin
                    state_d = ST_IDLE;
                end else if (filt_cnt_q >= FILT_LAST) begin
                    state_d = ST_FIRE;
                end else begin
                    filt_cnt_d = filt_cnt_q + FILT_ONE;
                end
            end
            ST_FIRE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!act_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Capture the bus on FIRE entry so data is valid alongside wr_stb.
        if (state_d == ST_FIRE && state_q != ST_FIRE) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = cpu_addr[12:0];
            wr_dat_d  = cpu_dato;
            wr_be_d   = {cpu_we_hi, cpu_we_lo};
        end
    end

    always_comb begin
        db_irq_d = db_irq_q;
        if (wr_stb_q && (wr_addr_q[12:1] == DB_WORD)) begin
            db_irq_d = 1'b1;
        end else if (irq_clr) begin
            db_irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            filt_cnt_q <= '0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_dat_q   <= '0;
            wr_be_q    <= '0;
            db_irq_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            filt_cnt_q <= filt_cnt_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_dat_q   <= wr_dat_d;
            wr_be_q    <= wr_be_d;
            db_irq_q   <= db_irq_d;
        end
    end

`ifdef WR_CNT_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_stb_q) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
`else
    assign wr_cnt = '0;
`endif

    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_dat  = wr_dat_q;
    assign wr_be   = wr_be_q;
    assign db_irq  = db_irq_q;

endmodule
